// File: rtl/vc_input_buffer.sv
// rtl/vc_input_buffer.sv - per-VC flit FIFOs with round-robin output arbitration and credit return
module vc_input_buffer #(
    parameter int VC_W          = 3,
    parameter int D_W           = 32,
    parameter int A_W           = 4,
    parameter int VC_FIFO_DEPTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    input  logic [VC_W-1:0] i_vc,
    input  logic [A_W-1:0]  i_addr,
    input  logic [D_W-1:0]  i_data,
    output logic            o_valid,
    output logic [VC_W-1:0] o_vc,
    output logic [A_W-1:0]  o_addr,
    output logic [D_W-1:0]  o_data,
    input  logic            o_ready,
    output logic [VC_W-1:0] o_credit,
    output logic [VC_W-1:0] o_full,
    output logic [VC_W-1:0] o_overflow
);
    localparam int PTR_W  = $clog2(VC_FIFO_DEPTH);
    localparam int IDX_W  = (VC_W > 1) ? $clog2(VC_W) : 1;
    localparam int FLIT_W = A_W + D_W;
    localparam logic [PTR_W-1:0] CNT_FULL = PTR_W'(VC_FIFO_DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VC_W - 1);

    logic [FLIT_W-1:0] mem [VC_W][VC_FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr [VC_W];
    logic [PTR_W-1:0]  rd_ptr [VC_W];
    logic [PTR_W-1:0]  count [VC_W];

    logic [IDX_W-1:0]  prio;
    logic [IDX_W-1:0]  lock_idx;
    logic              lock_vld;
    logic [IDX_W-1:0]  grant;
    logic [IDX_W-1:0]  cand;
    logic              found;
    logic [IDX_W-1:0]  wr_idx;
    logic              vc_legal;
    logic              wr_en;
    logic              xfer;
    logic [VC_W-1:0]   non_empty;
    logic [VC_W-1:0]   wr_vec;
    logic [VC_W-1:0]   ov_vec;
    logic [VC_W-1:0]   pop_vec;
    logic [VC_W-1:0]   grant_oh;

    // Per-VC status derived from the registered occupancy counters.
    always_comb begin
        non_empty = '0;
        o_full    = '0;
        for (int k = 0; k < VC_W; k++) begin
            non_empty[k] = (count[k] != '0);
            o_full[k]    = (count[k] == CNT_FULL);
        end
    end

    // Decode the incoming flit: only an exactly one-hot VC may write, and only when not full.
    always_comb begin
        wr_idx = '0;
        for (int k = 0; k < VC_W; k++) begin
            if (i_vc[k]) begin
                wr_idx = IDX_W'(k);
            end
        end
        vc_legal = $onehot(i_vc);
        wr_en    = i_valid && vc_legal && !o_full[wr_idx];
        wr_vec   = wr_en ? i_vc : '0;
        ov_vec   = (i_valid && vc_legal && o_full[wr_idx]) ? i_vc : '0;
    end

    // Round-robin pick from the priority pointer; a held grant overrides the search.
    always_comb begin
        grant = lock_idx;
        found = lock_vld;
        cand  = '0;
        for (int i = 0; i < VC_W; i++) begin
            cand = IDX_W'((int'(prio) + i) % VC_W);
            if (!found && non_empty[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    // Present the granted VC's head flit and form the pop vector.
    always_comb begin
        grant_oh = '0;
        for (int k = 0; k < VC_W; k++) begin
            grant_oh[k] = (grant == IDX_W'(k));
        end
        o_valid = |non_empty;
        o_vc    = o_valid ? grant_oh : '0;
        xfer    = o_valid && o_ready;
        pop_vec = xfer ? grant_oh : '0;
    end

    assign {o_addr, o_data} = mem[grant][rd_ptr[grant]];

    // Flit storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx][wr_ptr[wr_idx]] <= {i_addr, i_data};
        end
    end

    // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < VC_W; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < VC_W; k++) begin
                if (wr_vec[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
                end
                if (pop_vec[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
                end
                if (wr_vec[k] && !pop_vec[k]) begin
                    count[k] <= count[k] + PTR_W'(1);
                end else if (!wr_vec[k] && pop_vec[k]) begin
                    count[k] <= count[k] - PTR_W'(1);
                end
            end
        end
    end

    // Arbitration state, credit pulse and sticky overflow flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio       <= '0;
            lock_vld   <= 1'b0;
            lock_idx   <= '0;
            o_credit   <= '0;
            o_overflow <= '0;
        end else begin
            o_credit   <= pop_vec;
            o_overflow <= o_overflow | ov_vec;
            lock_vld   <= o_valid && !o_ready;
            lock_idx   <= grant;
            if (xfer) begin
                prio <= (grant == IDX_LAST) ? '0 : grant + IDX_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_vc_input_buffer.sv
// tb/tb_vc_input_buffer.sv - directed self-checking bench for vc_input_buffer
module tb_vc_input_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [2:0]  i_vc = '0;
    logic [3:0]  i_addr = '0;
    logic [31:0] i_data = '0;
    logic        o_valid;
    logic [2:0]  o_vc;
    logic [3:0]  o_addr;
    logic [31:0] o_data;
    logic        o_ready = 1'b0;
    logic [2:0]  o_credit;
    logic [2:0]  o_full;
    logic [2:0]  o_overflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vc_input_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_vc       (i_vc),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .o_vc       (o_vc),
        .o_addr     (o_addr),
        .o_data     (o_data),
        .o_ready    (o_ready),
        .o_credit   (o_credit),
        .o_full     (o_full),
        .o_overflow (o_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        i_valid = 1'b0;
        i_vc = '0;
        o_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push(input logic [2:0] vc, input logic [31:0] d);
        i_valid = 1'b1;
        i_vc = vc;
        i_addr = d[3:0];
        i_data = d;
        tick();
        i_valid = 1'b0;
        i_vc = '0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_o_valid: got %b expected 0", o_valid); end
        n_cmp++; if (o_vc !== 3'b000) begin n_bad++; $display("FAIL reset_o_vc: got %b expected 000", o_vc); end
        n_cmp++; if (o_credit !== 3'b000) begin n_bad++; $display("FAIL reset_o_credit: got %b expected 000", o_credit); end
        n_cmp++; if (o_full !== 3'b000) begin n_bad++; $display("FAIL reset_o_full: got %b expected 000", o_full); end
        n_cmp++; if (o_overflow !== 3'b000) begin n_bad++; $display("FAIL reset_o_overflow: got %b expected 000", o_overflow); end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_o_valid: got %b expected 0", o_valid); end
    endtask

    task automatic test_single_flit();
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_vc = 3'b010;
        i_addr = 4'h3;
        i_data = 32'hA5A5A5A5;
        tick();
        i_valid = 1'b0;
        i_vc = '0;
        n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL single_c1_valid: got %b expected 1", o_valid); end
        n_cmp++; if (o_vc !== 3'b010) begin n_bad++; $display("FAIL single_c1_vc: got %b expected 010", o_vc); end
        n_cmp++; if (o_data !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL single_c1_data: got %h expected a5a5a5a5", o_data); end
        n_cmp++; if (o_addr !== 4'h3) begin n_bad++; $display("FAIL single_c1_addr: got %h expected 3", o_addr); end
        n_cmp++; if (o_credit !== 3'b000) begin n_bad++; $display("FAIL single_c1_credit: got %b expected 000", o_credit); end
        tick();
        n_cmp++; if (o_credit !== 3'b010) begin n_bad++; $display("FAIL single_c2_credit: got %b expected 010", o_credit); end
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL single_c2_valid: got %b expected 0", o_valid); end
        n_cmp++; if (o_vc !== 3'b000) begin n_bad++; $display("FAIL single_c2_vc: got %b expected 000", o_vc); end
        tick();
        n_cmp++; if (o_credit !== 3'b000) begin n_bad++; $display("FAIL single_c3_credit: got %b expected 000", o_credit); end
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 0; i < 31; i++) begin
            push(3'b001, 32'h1000 + 32'(i));
            if (i == 29) begin
                n_cmp++; if (o_full !== 3'b000) begin n_bad++; $display("FAIL fill_30_full: got %b expected 000", o_full); end
            end
        end
        n_cmp++; if (o_full !== 3'b001) begin n_bad++; $display("FAIL fill_31_full: got %b expected 001", o_full); end
        n_cmp++; if (o_overflow !== 3'b000) begin n_bad++; $display("FAIL fill_31_overflow: got %b expected 000", o_overflow); end
        n_cmp++; if (o_data !== 32'h1000) begin n_bad++; $display("FAIL fill_31_head: got %h expected 00001000", o_data); end
        push(3'b001, 32'hDEAD0000);
        n_cmp++; if (o_overflow !== 3'b001) begin n_bad++; $display("FAIL fill_32_overflow: got %b expected 001", o_overflow); end
        n_cmp++; if (o_full !== 3'b001) begin n_bad++; $display("FAIL fill_32_full: got %b expected 001", o_full); end
        n_cmp++; if (o_data !== 32'h1000) begin n_bad++; $display("FAIL fill_32_head: got %h expected 00001000", o_data); end
        o_ready = 1'b1;
        for (int i = 0; i < 31; i++) begin
            n_cmp++; if (o_data !== 32'h1000 + 32'(i) || o_valid !== 1'b1) begin n_bad++; $display("FAIL fill_drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, o_valid, o_data, 32'h1000 + 32'(i)); end
            tick();
        end
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL fill_drained_valid: got %b expected 0", o_valid); end
        n_cmp++; if (o_full !== 3'b000) begin n_bad++; $display("FAIL fill_drained_full: got %b expected 000", o_full); end
        n_cmp++; if (o_overflow !== 3'b001) begin n_bad++; $display("FAIL fill_sticky_overflow: got %b expected 001", o_overflow); end
        n_cmp++; if (o_credit !== 3'b001) begin n_bad++; $display("FAIL fill_last_credit: got %b expected 001", o_credit); end
        push(3'b001, 32'h2222_0001);
        n_cmp++; if (o_data !== 32'h2222_0001) begin n_bad++; $display("FAIL wrap_x_data: got %h expected 22220001", o_data); end
        push(3'b001, 32'h2222_0002);
        n_cmp++; if (o_data !== 32'h2222_0002 || o_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_y_data: got valid=%b data=%h expected valid=1 data=22220002", o_valid, o_data); end
        n_cmp++; if (o_credit !== 3'b001) begin n_bad++; $display("FAIL wrap_x_credit: got %b expected 001", o_credit); end
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_empty_valid: got %b expected 0", o_valid); end
        n_cmp++; if (o_credit !== 3'b001) begin n_bad++; $display("FAIL wrap_y_credit: got %b expected 001", o_credit); end
    endtask

    task automatic test_overflow_on_pop();
        apply_reset();
        n_cmp++; if (o_overflow !== 3'b000) begin n_bad++; $display("FAIL ovpop_reset_clear: got %b expected 000", o_overflow); end
        for (int i = 0; i < 31; i++) begin
            push(3'b010, 32'h3000 + 32'(i));
        end
        n_cmp++; if (o_full !== 3'b010) begin n_bad++; $display("FAIL ovpop_full: got %b expected 010", o_full); end
        o_ready = 1'b1;
        push(3'b010, 32'h0000_0BAD);
        n_cmp++; if (o_overflow !== 3'b010) begin n_bad++; $display("FAIL ovpop_overflow: got %b expected 010", o_overflow); end
        n_cmp++; if (o_full !== 3'b000) begin n_bad++; $display("FAIL ovpop_full_after: got %b expected 000", o_full); end
        n_cmp++; if (o_credit !== 3'b010) begin n_bad++; $display("FAIL ovpop_credit: got %b expected 010", o_credit); end
        for (int i = 1; i < 31; i++) begin
            n_cmp++; if (o_data !== 32'h3000 + 32'(i) || o_valid !== 1'b1) begin n_bad++; $display("FAIL ovpop_drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, o_valid, o_data, 32'h3000 + 32'(i)); end
            tick();
        end
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL ovpop_dropped_absent: got %b expected 0", o_valid); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_credit;
        apply_reset();
        for (int n = 0; n < 2; n++) begin
            for (int v = 0; v < 3; v++) begin
                push(3'(1 << v), 32'h5000 + 32'(n * 16 + v));
            end
        end
        o_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            exp_credit = (t == 0) ? 3'b000 : 3'(1 << ((t - 1) % 3));
            n_cmp++; if (o_vc !== 3'(1 << (t % 3))) begin n_bad++; $display("FAIL rr_vc_%0d: got %b expected %b", t, o_vc, 3'(1 << (t % 3))); end
            n_cmp++; if (o_data !== 32'h5000 + 32'((t / 3) * 16 + (t % 3))) begin n_bad++; $display("FAIL rr_data_%0d: got %h expected %h", t, o_data, 32'h5000 + 32'((t / 3) * 16 + (t % 3))); end
            n_cmp++; if (o_credit !== exp_credit) begin n_bad++; $display("FAIL rr_credit_%0d: got %b expected %b", t, o_credit, exp_credit); end
            tick();
        end
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rr_end_valid: got %b expected 0", o_valid); end
        n_cmp++; if (o_credit !== 3'b100) begin n_bad++; $display("FAIL rr_end_credit: got %b expected 100", o_credit); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        push(3'b100, 32'hC0C0_0002);
        n_cmp++; if (o_vc !== 3'b100) begin n_bad++; $display("FAIL bp_initial_vc: got %b expected 100", o_vc); end
        push(3'b001, 32'hC0C0_0000);
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (o_vc !== 3'b100 || o_data !== 32'hC0C0_0002) begin n_bad++; $display("FAIL bp_hold_%0d: got vc=%b data=%h expected vc=100 data=c0c00002", c, o_vc, o_data); end
            tick();
        end
        o_ready = 1'b1;
        tick();
        n_cmp++; if (o_credit !== 3'b100) begin n_bad++; $display("FAIL bp_credit_vc2: got %b expected 100", o_credit); end
        n_cmp++; if (o_vc !== 3'b001 || o_data !== 32'hC0C0_0000) begin n_bad++; $display("FAIL bp_next_vc0: got vc=%b data=%h expected vc=001 data=c0c00000", o_vc, o_data); end
        tick();
        n_cmp++; if (o_credit !== 3'b001 || o_valid !== 1'b0) begin n_bad++; $display("FAIL bp_done: got credit=%b valid=%b expected credit=001 valid=0", o_credit, o_valid); end
    endtask

    task automatic test_illegal_vc();
        apply_reset();
        push(3'b010, 32'h7777_0001);
        push(3'b011, 32'h0000_BAD1);
        push(3'b000, 32'h0000_BAD2);
        n_cmp++; if (o_overflow !== 3'b000) begin n_bad++; $display("FAIL illegal_overflow: got %b expected 000", o_overflow); end
        n_cmp++; if (o_full !== 3'b000) begin n_bad++; $display("FAIL illegal_full: got %b expected 000", o_full); end
        n_cmp++; if (o_valid !== 1'b1 || o_vc !== 3'b010) begin n_bad++; $display("FAIL illegal_head_vc: got valid=%b vc=%b expected valid=1 vc=010", o_valid, o_vc); end
        n_cmp++; if (o_data !== 32'h7777_0001) begin n_bad++; $display("FAIL illegal_head_data: got %h expected 77770001", o_data); end
        o_ready = 1'b1;
        tick();
        n_cmp++; if (o_credit !== 3'b010 || o_valid !== 1'b0) begin n_bad++; $display("FAIL illegal_nothing_queued: got credit=%b valid=%b expected credit=010 valid=0", o_credit, o_valid); end
        tick();
        n_cmp++; if (o_valid !== 1'b0 || o_credit !== 3'b000) begin n_bad++; $display("FAIL illegal_idle: got valid=%b credit=%b expected valid=0 credit=000", o_valid, o_credit); end
    endtask

    task automatic test_reset_mid_stream();
        apply_reset();
        push(3'b001, 32'h8000_0000);
        push(3'b001, 32'h8000_0001);
        push(3'b010, 32'h8000_0010);
        push(3'b010, 32'h8000_0011);
        for (int i = 0; i < 32; i++) begin
            push(3'b100, 32'h8000_0100 + 32'(i));
        end
        n_cmp++; if (o_full !== 3'b100 || o_overflow !== 3'b100) begin n_bad++; $display("FAIL rmid_pre_flags: got full=%b overflow=%b expected full=100 overflow=100", o_full, o_overflow); end
        o_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (o_valid !== 1'b0 || o_vc !== 3'b000) begin n_bad++; $display("FAIL rmid_async_out: got valid=%b vc=%b expected valid=0 vc=000", o_valid, o_vc); end
        n_cmp++; if (o_credit !== 3'b000) begin n_bad++; $display("FAIL rmid_async_credit: got %b expected 000", o_credit); end
        n_cmp++; if (o_full !== 3'b000 || o_overflow !== 3'b000) begin n_bad++; $display("FAIL rmid_async_flags: got full=%b overflow=%b expected 000 000", o_full, o_overflow); end
        tick();
        n_cmp++; if (o_credit !== 3'b000 || o_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_held_reset: got credit=%b valid=%b expected credit=000 valid=0", o_credit, o_valid); end
        rst = 1'b0;
        tick();
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_released_valid: got %b expected 0", o_valid); end
        push(3'b100, 32'h9999_0009);
        n_cmp++; if (o_valid !== 1'b1 || o_vc !== 3'b100 || o_data !== 32'h9999_0009) begin n_bad++; $display("FAIL rmid_new_flit: got valid=%b vc=%b data=%h expected valid=1 vc=100 data=99990009", o_valid, o_vc, o_data); end
        tick();
        n_cmp++; if (o_credit !== 3'b100 || o_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_new_credit: got credit=%b valid=%b expected credit=100 valid=0", o_credit, o_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_flit();
        test_fill();
        test_overflow_on_pop();
        test_round_robin();
        test_backpressure();
        test_illegal_vc();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
